// File: rtl/output_port_arbiter_pkg.sv
// Shared definitions for the output-queue blocks: arbiter state encoding and a
// ceiling-log2 helper used for index and counter widths.
package output_port_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so derived vectors always have a bit.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/output_port_arbiter_picker.sv
// Round-robin search: first requesting index after last_idx, wrapping modulo
// NUM_INPUTS, with last_idx itself checked last.
module rr_priority_picker
  import output_port_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS = 4,
  localparam int unsigned IDX_W      = log2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]      last_idx,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    next_idx = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = int'(NUM_INPUTS); off >= 1; off--) begin
      cand     = (int'(last_idx) + off) % int'(NUM_INPUTS);
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        next_idx = cand_idx;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Packet-granular round-robin arbiter: drains whole packets from one output
// queue at a time onto a shared port, with a per-packet word watchdog.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned NUM_INPUTS    = 4,
  parameter int unsigned MAX_PKT_WORDS = 256
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_INPUTS*(CTRL_WIDTH+DATA_WIDTH)-1:0] req_dout,
  input  logic [NUM_INPUTS-1:0]                         req_empty,
  output logic [NUM_INPUTS-1:0]                         req_rd_en,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic [CTRL_WIDTH-1:0]                         out_ctrl,
  output logic                                          out_wr,
  input  logic                                          out_rdy,
  output logic [NUM_INPUTS-1:0]                         grant,
  output logic [NUM_INPUTS-1:0]                         err_oversize,
  input  logic                                          err_clr
);

  localparam int unsigned WORD_W = CTRL_WIDTH + DATA_WIDTH;
  localparam int unsigned IDX_W  = log2(NUM_INPUTS);
  localparam int unsigned CNT_W  = log2(MAX_PKT_WORDS + 1);

  arb_state_e              state;
  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    data_phase;
  logic [CNT_W-1:0]        word_cnt;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic [WORD_W-1:0]       head_word;
  logic [CTRL_WIDTH-1:0]   head_ctrl;
  logic                    pop;
  logic                    eop;
  logic                    oversize;
  logic [CNT_W-1:0]        cnt_next;
  logic [NUM_INPUTS-1:0]   err_set;

  rr_priority_picker #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_picker (
    .req      (~req_empty),
    .last_idx (last_grant),
    .next_idx (pick_idx),
    .valid    (pick_valid)
  );

  // Pop the granted queue whenever it has a word and downstream has room.
  always_comb begin
    req_rd_en = '0;
    if (state == SEND) begin
      req_rd_en[grant_idx] = out_rdy & ~req_empty[grant_idx];
    end
  end

  // Framing and watchdog decode of the word being popped this cycle.
  always_comb begin
    head_word = req_dout[grant_idx*WORD_W +: WORD_W];
    head_ctrl = head_word[WORD_W-1 -: CTRL_WIDTH];
    pop       = |req_rd_en;
    cnt_next  = word_cnt + CNT_W'(1);
    eop       = pop && (head_ctrl != '0) && data_phase;
    oversize  = pop && !eop && (cnt_next == CNT_W'(MAX_PKT_WORDS));
    err_set   = '0;
    if (oversize) begin
      err_set[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB;
      last_grant   <= IDX_W'(NUM_INPUTS - 1);
      grant_idx    <= '0;
      grant        <= '0;
      data_phase   <= 1'b0;
      word_cnt     <= '0;
      out_wr       <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
      err_oversize <= '0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        {out_ctrl, out_data} <= head_word;
      end
      // A watchdog set in the same cycle as a clear survives the clear.
      err_oversize <= (err_clr ? '0 : err_oversize) | err_set;

      case (state)
        ARB: begin
          if (pick_valid) begin
            grant_idx  <= pick_idx;
            grant      <= NUM_INPUTS'(1) << pick_idx;
            data_phase <= 1'b0;
            word_cnt   <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (pop) begin
            word_cnt <= cnt_next;
            if (head_ctrl == '0) begin
              data_phase <= 1'b1;
            end
            if (eop || oversize) begin
              last_grant <= grant_idx;
              grant      <= '0;
              state      <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
